// File: rtl/qam_symbol_mapper.sv
// QPSK / 16-QAM Gray symbol mapper fed from a 1-cycle-latency byte FIFO.
// Optional: define SCRAMBLE_EN to whiten each byte with a 7-bit x^7+x^4+1 LFSR.
module qam_symbol_mapper #(
    parameter int SYM_DIV = 4,
    parameter int IQ_W    = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic            mode,
    input  logic            fifo_empty,
    input  logic [7:0]      fifo_data,
    output logic            fifo_rd_en,
    output logic [IQ_W-1:0] i_out,
    output logic [IQ_W-1:0] q_out,
    output logic            sym_valid,
    output logic            underrun
);

    localparam int DW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SYM_DIV - 1);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2
    } fetch_state_t;

    fetch_state_t f_state, f_next;

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [7:0]    nxt_byte;
    logic          nxt_vld;
    logic [7:0]    sreg;
    logic [2:0]    rem;
    logic          mode_q;
    logic          emitted;
    logic          load;
    logic          shift_emit;
    logic          emit;
    logic [7:0]    loaded_byte;
    logic [7:0]    src_byte;
    logic          src_mode;
    logic [2:0]    i_map;
    logic [2:0]    q_map;

    function automatic logic [2:0] qpsk_lvl(input logic b);
        return b ? 3'b110 : 3'b010;
    endfunction

    function automatic logic [2:0] gray_lvl(input logic [1:0] b);
        logic [2:0] lvl;
        case (b)
            2'b00:   lvl = 3'b101;
            2'b01:   lvl = 3'b111;
            2'b11:   lvl = 3'b001;
            default: lvl = 3'b011;
        endcase
        return lvl;
    endfunction

    assign tick = en && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           div_cnt <= '0;
        else if (!en || tick)   div_cnt <= '0;
        else                    div_cnt <= div_cnt + 1'b1;
    end

    // A started read always finishes, so F_REQ/F_WAIT ignore en.
    always_comb begin
        f_next = f_state;
        case (f_state)
            F_IDLE:  if (en && !nxt_vld && !fifo_empty) f_next = F_REQ;
            F_REQ:   f_next = F_WAIT;
            F_WAIT:  f_next = F_IDLE;
            default: f_next = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_state    <= F_IDLE;
            fifo_rd_en <= 1'b0;
        end else begin
            f_state    <= f_next;
            fifo_rd_en <= (f_next == F_REQ);
        end
    end

    assign load       = tick && (rem == 3'd0) && nxt_vld;
    assign shift_emit = tick && (rem != 3'd0);
    assign emit       = load || shift_emit;

    // Capture takes priority over the load-clear of nxt_vld.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nxt_byte <= 8'h00;
            nxt_vld  <= 1'b0;
        end else if (f_state == F_WAIT) begin
            nxt_byte <= fifo_data;
            nxt_vld  <= 1'b1;
        end else if (load) begin
            nxt_vld  <= 1'b0;
        end
    end

`ifdef SCRAMBLE_EN
    logic [6:0] lfsr;
    logic [6:0] lfsr_adv;
    logic [7:0] scr_mask;

    always_comb begin
        lfsr_adv = lfsr;
        scr_mask = 8'h00;
        for (int k = 0; k < 8; k++) begin
            scr_mask[7-k] = lfsr_adv[6] ^ lfsr_adv[3];
            lfsr_adv      = {lfsr_adv[5:0], lfsr_adv[6] ^ lfsr_adv[3]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    lfsr <= 7'h7F;
        else if (!en)    lfsr <= 7'h7F;
        else if (load)   lfsr <= lfsr_adv;
    end

    assign loaded_byte = nxt_byte ^ scr_mask;
`else
    assign loaded_byte = nxt_byte;
`endif

    // The first symbol of a byte is emitted straight from the byte being loaded.
    assign src_byte = load ? loaded_byte : sreg;
    assign src_mode = load ? mode : mode_q;
    assign i_map    = src_mode ? gray_lvl(src_byte[7:6]) : qpsk_lvl(src_byte[7]);
    assign q_map    = src_mode ? gray_lvl(src_byte[5:4]) : qpsk_lvl(src_byte[6]);

    // rem counts symbols still to send after the one emitted this tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg   <= 8'h00;
            rem    <= 3'd0;
            mode_q <= 1'b0;
        end else if (!en) begin
            rem    <= 3'd0;
        end else if (load) begin
            sreg   <= mode ? {loaded_byte[3:0], 4'h0} : {loaded_byte[5:0], 2'b00};
            rem    <= mode ? 3'd1 : 3'd3;
            mode_q <= mode;
        end else if (shift_emit) begin
            sreg   <= mode_q ? {sreg[3:0], 4'h0} : {sreg[5:0], 2'b00};
            rem    <= rem - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_out     <= '0;
            q_out     <= '0;
            sym_valid <= 1'b0;
        end else begin
            sym_valid <= emit;
            if (emit) begin
                i_out <= i_map;
                q_out <= q_map;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            emitted  <= 1'b0;
            underrun <= 1'b0;
        end else if (!en) begin
            emitted  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (emit) emitted <= 1'b1;
            if (tick && (rem == 3'd0) && !nxt_vld && emitted) underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Directed self-checking bench for qam_symbol_mapper with a small FIFO model.
module tb_qam_symbol_mapper;

    localparam int SYM_DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic [2:0] i_out;
    logic [2:0] q_out;
    logic       sym_valid;
    logic       underrun;

    qam_symbol_mapper #(.SYM_DIV(SYM_DIV), .IQ_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .mode       (mode),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .i_out      (i_out),
        .q_out      (q_out),
        .sym_valid  (sym_valid),
        .underrun   (underrun)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data appears the cycle after a pop request
    logic [7:0] fifo_mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (rd_ptr != wr_ptr) begin
                fifo_data <= fifo_mem[rd_ptr % 64];
                rd_ptr    <= rd_ptr + 1;
            end
            pop_cnt <= pop_cnt + 1;
        end
    end

    // scoreboard
    logic [5:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int start_cyc = 0;
    int last_sym_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // drivers
    task automatic push_byte(input logic [7:0] b);
        fifo_mem[wr_ptr % 64] = b;
        wr_ptr++;
    endtask

    task automatic exp_sym(input int i, input int q);
        logic [2:0] iv;
        logic [2:0] qv;
        iv = 3'(i);
        qv = 3'(q);
        exp_q.push_back({iv, qv});
    endtask

    task automatic start_en();
        en = 1'b1;
        start_cyc = cyc;
    endtask

    // timing_mode: 0 = none, 1 = first symbol latency from en, 2 = gap from previous symbol
    task automatic expect_syms(input int n, input int timing_mode);
        int waited;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!sym_valid && waited < 40);
            if (!sym_valid) begin
                check("sym_timeout", 32'd0, 32'd1);
                exp_q.delete();
                return;
            end
            if (k == 0 && timing_mode == 1)
                check("first_latency", 32'(cyc - start_cyc), 32'(SYM_DIV));
            else if (k > 0 || timing_mode == 2)
                check("sym_gap", 32'(cyc - last_sym_cyc), 32'(SYM_DIV));
            last_sym_cyc = cyc;
            if (exp_q.size() == 0) check("sym_unexpected", 32'd1, 32'd0);
            else check("sym_iq", {26'd0, i_out, q_out}, {26'd0, exp_q.pop_front()});
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
        check({tag, "_i"}, {29'd0, i_out}, 32'd0);
        check({tag, "_q"}, {29'd0, q_out}, 32'd0);
        check({tag, "_valid"}, {31'd0, sym_valid}, 32'd0);
        check({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0;
        logic seen;

        // reset
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // QPSK 0xB4
        mode = 1'b0;
        push_byte(8'hB4);
        exp_sym(-2, 2); exp_sym(-2, -2); exp_sym(2, -2); exp_sym(2, 2);
        p0 = pop_cnt;
        start_en();
        expect_syms(4, 1);
        en = 1'b0;
        check("qpsk_pops", 32'(pop_cnt - p0), 32'd1);
        repeat (2) @(negedge clk);

        // 16-QAM 0x6C
        mode = 1'b1;
        push_byte(8'h6C);
        exp_sym(-1, 3); exp_sym(1, -3);
        p0 = pop_cnt;
        start_en();
        expect_syms(2, 1);
        en = 1'b0;
        check("qam16_pops", 32'(pop_cnt - p0), 32'd1);
        check("qam16_no_underrun", {31'd0, underrun}, 32'd0);
        repeat (2) @(negedge clk);

        // back-to-back 0x00, 0xFF in QPSK
        mode = 1'b0;
        push_byte(8'h00);
        push_byte(8'hFF);
        for (int k = 0; k < 4; k++) exp_sym(2, 2);
        for (int k = 0; k < 4; k++) exp_sym(-2, -2);
        p0 = pop_cnt;
        start_en();
        expect_syms(8, 1);
        check("stream_pops", 32'(pop_cnt - p0), 32'd2);
        check("stream_no_underrun", {31'd0, underrun}, 32'd0);
        en = 1'b0;
        repeat (2) @(negedge clk);

        // underrun after a single byte
        push_byte(8'hB4);
        exp_sym(-2, 2); exp_sym(-2, -2); exp_sym(2, -2); exp_sym(2, 2);
        start_en();
        expect_syms(4, 1);
        check("ur_before", {31'd0, underrun}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < SYM_DIV; k++) begin
            @(negedge clk);
            if (sym_valid) seen = 1'b1;
        end
        check("ur_no_sym", {31'd0, seen}, 32'd0);
        check("ur_set", {31'd0, underrun}, 32'd1);
        repeat (3) @(negedge clk);
        check("ur_sticky", {31'd0, underrun}, 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("ur_clear", {31'd0, underrun}, 32'd0);
        repeat (2) @(negedge clk);

        // mode toggled mid-byte: rest of 0xB4 stays QPSK, 0x6C goes out as 16-QAM
        mode = 1'b0;
        push_byte(8'hB4);
        push_byte(8'h6C);
        exp_sym(-2, 2); exp_sym(-2, -2); exp_sym(2, -2); exp_sym(2, 2);
        exp_sym(-1, 3); exp_sym(1, -3);
        p0 = pop_cnt;
        start_en();
        expect_syms(1, 1);
        mode = 1'b1;
        expect_syms(5, 2);
        check("mode_pops", 32'(pop_cnt - p0), 32'd2);
        en = 1'b0;
        mode = 1'b0;
        repeat (2) @(negedge clk);

        // reset mid-byte while the refetch sits in F_WAIT
        push_byte(8'hFF);
        push_byte(8'h00);
        exp_sym(-2, -2);
        start_en();
        expect_syms(1, 1);
        @(negedge clk);
        check("refetch_req", {31'd0, fifo_rd_en}, 32'd1);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check_outputs_zero("mid_reset");
        en = 1'b0;
        push_byte(8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (fifo_rd_en) seen = 1'b1;
        end
        check("rd_idle_after_reset", {31'd0, seen}, 32'd0);
        exp_sym(2, 2);
        start_en();
        @(negedge clk);
        check("rd_after_en", {31'd0, fifo_rd_en}, 32'd1);
        expect_syms(1, 1);
        en = 1'b0;
        repeat (2) @(negedge clk);

        // report
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
